adma_dm_ax_sched: RTL and testbench

- Round-robin scheduler that shares one AXI address-channel issuer (AR or AW) between CH_NUM DMA channels.
- Accepts per-channel transaction requests and tags each with an AxID derived from the channel index.
- Enforces a per-channel outstanding-transaction limit, released by completion reports from the R/B response path.
- Sits between the channel descriptor engines and the AX issuer's atx_* valid/ready input.

---
 rtl/adma_dm_pkg.sv | 31 +++
 rtl/adma_rr_arb.sv | 58 +++++
 rtl/adma_dm_ax_sched.sv | 146 ++++++++++++++
 tb/tb_adma_dm_ax_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_dm_pkg.sv
// adma_dm_pkg: shared types, constants and helpers for the ADMA data-mover blocks.
// Rev 1.0 - initial release.
`default_nettype none

package adma_dm_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    localparam int AX_ID_W_MAX   = 16;
    localparam int AX_ADDR_W_MAX = 64;
    localparam int AX_LEN_W_MAX  = 8;

    typedef struct packed {
        logic [AX_ID_W_MAX-1:0]   id;
        logic [AX_ADDR_W_MAX-1:0] addr;
        logic [AX_LEN_W_MAX-1:0]  len;
        logic [1:0]               burst;
    } ax_info_t;

    // Width of a channel index; never below 1 so single-bit selects stay legal.
    function automatic int ch_idx_w(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adma_rr_arb.sv
// adma_rr_arb: rotating-pointer round-robin arbiter; the pointer moves to the winner on upd.
// Rev 1.0 - initial release.
`default_nettype none

module adma_rr_arb
    import adma_dm_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = ch_idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic          upd,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            idx;

    // Search starts one past the last winner so the previous grantee gets lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd && found) begin
            ptr_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/adma_dm_ax_sched.sv
// adma_dm_ax_sched: round-robin sharing of one AXI AR/AW issuer among CH_NUM DMA channels,
// with per-channel outstanding limits released by R/B completion reports. Rev 1.0.
`default_nettype none

module adma_dm_ax_sched
    import adma_dm_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int ATX_ADDR_W = 32,
    parameter int MST_ID_W   = 5,
    parameter int ATX_LEN_W  = 8,
    parameter int CH_OSTD    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CH_NUM*ATX_ADDR_W-1:0]   ch_axaddr_i,
    input  logic [CH_NUM*ATX_LEN_W-1:0]    ch_axlen_i,
    input  logic [CH_NUM*2-1:0]            ch_axburst_i,
    input  logic [CH_NUM-1:0]              ch_vld_i,
    output logic [CH_NUM-1:0]              ch_rdy_o,
    output logic [MST_ID_W-1:0]            atx_axid_o,
    output logic [ATX_ADDR_W-1:0]          atx_axaddr_o,
    output logic [ATX_LEN_W-1:0]           atx_axlen_o,
    output logic [1:0]                     atx_axburst_o,
    output logic                           atx_vld_o,
    input  logic                           atx_rdy_i,
    input  logic [MST_ID_W-1:0]            cpl_id_i,
    input  logic                           cpl_vld_i,
    output logic [CH_NUM*4-1:0]            ch_ostd_o,
    output logic                           err_o
);

    localparam int CH_IDX_W = ch_idx_w(CH_NUM);

    logic [CH_NUM-1:0][3:0]  cnt_q, cnt_d;
    logic                    atx_vld_q, atx_vld_d;
    logic [MST_ID_W-1:0]     axid_q, axid_d;
    logic [ATX_ADDR_W-1:0]   axaddr_q, axaddr_d;
    logic [ATX_LEN_W-1:0]    axlen_q, axlen_d;
    logic [1:0]              axburst_q, axburst_d;
    logic                    err_q, err_d;

    logic [CH_NUM-1:0]       elig;
    logic                    load_en;
    logic [CH_NUM-1:0]       gnt;
    logic [CH_IDX_W-1:0]     gnt_idx;
    logic                    any_gnt;
    logic [CH_IDX_W-1:0]     cpl_idx;
    logic                    unused_cpl_id;

    // Eligibility uses the registered count, so a same-cycle completion frees the slot next cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            elig[i] = ch_vld_i[i] && (cnt_q[i] < 4'(CH_OSTD));
        end
    end

    assign load_en = !atx_vld_q || atx_rdy_i;
    assign any_gnt = |gnt;

    adma_rr_arb #(
        .N (CH_NUM)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .en      (load_en),
        .upd     (any_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign ch_rdy_o = gnt;

    always_comb begin
        atx_vld_d = atx_vld_q;
        axid_d    = axid_q;
        axaddr_d  = axaddr_q;
        axlen_d   = axlen_q;
        axburst_d = axburst_q;
        if (any_gnt) begin
            atx_vld_d = 1'b1;
            axid_d    = MST_ID_W'(gnt_idx);
            axaddr_d  = ch_axaddr_i[int'(gnt_idx)*ATX_ADDR_W +: ATX_ADDR_W];
            axlen_d   = ch_axlen_i[int'(gnt_idx)*ATX_LEN_W +: ATX_LEN_W];
            axburst_d = ch_axburst_i[int'(gnt_idx)*2 +: 2];
        end else if (atx_rdy_i) begin
            atx_vld_d = 1'b0;
        end
    end

    assign cpl_idx       = cpl_id_i[CH_IDX_W-1:0];
    assign unused_cpl_id = ^cpl_id_i;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int i = 0; i < CH_NUM; i++) begin
            if (gnt[i]) begin
                cnt_d[i] = cnt_d[i] + 4'd1;
            end
            if (cpl_vld_i && (int'(cpl_idx) == i) && (cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_d[i] - 4'd1;
            end
        end
        if (cpl_vld_i) begin
            if (int'(cpl_idx) >= CH_NUM) begin
                err_d = 1'b1;
            end else if (cnt_q[int'(cpl_idx)] == 4'd0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            atx_vld_q <= 1'b0;
            axid_q    <= '0;
            axaddr_q  <= '0;
            axlen_q   <= '0;
            axburst_q <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            atx_vld_q <= atx_vld_d;
            axid_q    <= axid_d;
            axaddr_q  <= axaddr_d;
            axlen_q   <= axlen_d;
            axburst_q <= axburst_d;
            err_q     <= err_d;
        end
    end

    assign atx_vld_o     = atx_vld_q;
    assign atx_axid_o    = axid_q;
    assign atx_axaddr_o  = axaddr_q;
    assign atx_axlen_o   = axlen_q;
    assign atx_axburst_o = axburst_q;
    assign ch_ostd_o     = cnt_q;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_adma_dm_ax_sched.sv
// tb_adma_dm_ax_sched: directed scenarios plus randomized traffic against a behavioural model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_adma_dm_ax_sched;

    localparam int CH  = 4;
    localparam int AW  = 32;
    localparam int IDW = 5;
    localparam int LW  = 8;
    localparam int OST = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CH*AW-1:0]  ch_axaddr = '0;
    logic [CH*LW-1:0]  ch_axlen = '0;
    logic [CH*2-1:0]   ch_axburst = '0;
    logic [CH-1:0]     ch_vld = '0;
    logic [CH-1:0]     ch_rdy;
    logic [IDW-1:0]    atx_axid;
    logic [AW-1:0]     atx_axaddr;
    logic [LW-1:0]     atx_axlen;
    logic [1:0]        atx_axburst;
    logic              atx_vld;
    logic              atx_rdy = 1'b0;
    logic [IDW-1:0]    cpl_id = '0;
    logic              cpl_vld = 1'b0;
    logic [CH*4-1:0]   ch_ostd;
    logic              err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_cnt [CH];
    int          m_last;
    bit          m_vld;
    int          m_id;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [1:0]  m_burst;
    bit          m_err;

    always #5 clk = ~clk;

    adma_dm_ax_sched #(
        .CH_NUM(CH), .ATX_ADDR_W(AW), .MST_ID_W(IDW), .ATX_LEN_W(LW), .CH_OSTD(OST)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_axaddr_i(ch_axaddr), .ch_axlen_i(ch_axlen), .ch_axburst_i(ch_axburst),
        .ch_vld_i(ch_vld), .ch_rdy_o(ch_rdy),
        .atx_axid_o(atx_axid), .atx_axaddr_o(atx_axaddr), .atx_axlen_o(atx_axlen),
        .atx_axburst_o(atx_axburst), .atx_vld_o(atx_vld), .atx_rdy_i(atx_rdy),
        .cpl_id_i(cpl_id), .cpl_vld_i(cpl_vld), .ch_ostd_o(ch_ostd), .err_o(err)
    );

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_last  = CH - 1;
        m_vld   = 0;
        m_id    = 0;
        m_addr  = '0;
        m_len   = '0;
        m_burst = '0;
        m_err   = 0;
    endfunction

    // Channel that should win now, or -1; fair rotation after the previous winner.
    function automatic int model_winner();
        if (m_vld && !atx_rdy) return -1;
        for (int k = 1; k <= CH; k++) begin
            int c;
            c = (m_last + k) % CH;
            if (ch_vld[c] && m_cnt[c] < OST) return c;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] model_rdy();
        logic [CH-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [CH*4-1:0] model_ostd();
        logic [CH*4-1:0] v;
        for (int i = 0; i < CH; i++) v[i*4 +: 4] = 4'(m_cnt[i]);
        return v;
    endfunction

    // Advance one clock and apply the transaction rules to the model; no comparisons here.
    task automatic tick();
        int w;
        int c;
        int old_cnt [CH];
        w = model_winner();
        for (int i = 0; i < CH; i++) old_cnt[i] = m_cnt[i];
        @(posedge clk);
        if (w >= 0) begin
            m_last  = w;
            m_vld   = 1;
            m_id    = w;
            m_addr  = ch_axaddr[w*AW +: AW];
            m_len   = ch_axlen[w*LW +: LW];
            m_burst = ch_axburst[w*2 +: 2];
            m_cnt[w]++;
        end else if (atx_rdy) begin
            m_vld = 0;
        end
        if (cpl_vld) begin
            c = int'(cpl_id) % CH;
            if (old_cnt[c] == 0) m_err = 1;
            else m_cnt[c]--;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_vld = '0; atx_rdy = 1'b0; cpl_vld = 1'b0; cpl_id = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (atx_vld !== 1'b0 || atx_axid !== '0 || atx_axaddr !== '0 || atx_axlen !== '0 || atx_axburst !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%b id=%h addr=%h len=%h burst=%h, expected all 0",
                     atx_vld, atx_axid, atx_axaddr, atx_axlen, atx_axburst);
        end
        checks++;
        if (ch_ostd !== '0 || err !== 1'b0 || ch_rdy !== '0) begin
            errors++;
            $display("FAIL reset_state: ostd=%h err=%b rdy=%b, expected 0", ch_ostd, err, ch_rdy);
        end
    endtask

    task automatic test_single();
        do_reset();
        ch_axaddr[0*AW +: AW] = 32'h1000;
        ch_axlen[0*LW +: LW]  = 8'd3;
        ch_axburst[1:0]       = 2'd1;
        ch_vld = 4'b0001; atx_rdy = 1'b1;
        #1;
        checks++;
        if (ch_rdy !== 4'b0001) begin
            errors++; $display("FAIL single_rdy: got %b expected 0001", ch_rdy);
        end
        tick();
        ch_vld = '0;
        checks++;
        if (atx_vld !== 1'b1 || atx_axid !== 5'd0 || atx_axaddr !== 32'h1000 ||
            atx_axlen !== 8'd3 || atx_axburst !== 2'd1) begin
            errors++;
            $display("FAIL single_issue: vld=%b id=%0d addr=%h len=%0d burst=%0d expected 1/0/1000/3/1",
                     atx_vld, atx_axid, atx_axaddr, atx_axlen, atx_axburst);
        end
        checks++;
        if (ch_ostd !== 16'h0001) begin
            errors++; $display("FAIL single_ostd: got %h expected 0001", ch_ostd);
        end
        tick();
        checks++;
        if (atx_vld !== 1'b0) begin
            errors++; $display("FAIL single_drop: atx_vld=%b expected 0", atx_vld);
        end
    endtask

    task automatic test_fill();
        logic [IDW-1:0] exp_id;
        do_reset();
        for (int i = 0; i < CH; i++) begin
            ch_axaddr[i*AW +: AW] = 32'h2000 + 32'(i) * 32'h100;
            ch_axlen[i*LW +: LW]  = 8'(i + 1);
        end
        ch_vld = 4'b1111; atx_rdy = 1'b1;
        for (int n = 0; n < 2 * CH; n++) begin
            #1;
            checks++;
            if (ch_rdy !== 4'(1 << (n % CH))) begin
                errors++; $display("FAIL fill_order[%0d]: rdy=%b expected %b", n, ch_rdy, 4'(1 << (n % CH)));
            end
            tick();
            exp_id = 5'(n % CH);
            checks++;
            if (atx_vld !== 1'b1 || atx_axid !== exp_id) begin
                errors++; $display("FAIL fill_issue[%0d]: vld=%b id=%0d expected 1/%0d", n, atx_vld, atx_axid, exp_id);
            end
        end
        #1;
        checks++;
        if (ch_rdy !== 4'b0000 || ch_ostd !== 16'h2222) begin
            errors++; $display("FAIL fill_limit: rdy=%b ostd=%h expected 0000/2222", ch_rdy, ch_ostd);
        end
        tick();
        checks++;
        if (atx_vld !== 1'b0) begin
            errors++; $display("FAIL fill_vld_fall: atx_vld=%b expected 0", atx_vld);
        end
        ch_vld = '0;
    endtask

    task automatic test_stall();
        logic [IDW-1:0] s_id;
        logic [AW-1:0]  s_addr;
        logic [LW-1:0]  s_len;
        do_reset();
        ch_vld = 4'b1111; atx_rdy = 1'b1;
        tick();
        atx_rdy = 1'b0;
        s_id = atx_axid; s_addr = atx_axaddr; s_len = atx_axlen;
        for (int n = 0; n < 5; n++) begin
            ch_axaddr = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++;
            if (ch_rdy !== 4'b0000) begin
                errors++; $display("FAIL stall_rdy[%0d]: rdy=%b expected 0000", n, ch_rdy);
            end
            tick();
            checks++;
            if (atx_vld !== 1'b1 || atx_axid !== s_id || atx_axaddr !== s_addr || atx_axlen !== s_len) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld=%b id=%0d addr=%h len=%0d expected 1/%0d/%h/%0d",
                         n, atx_vld, atx_axid, atx_axaddr, atx_axlen, s_id, s_addr, s_len);
            end
        end
        atx_rdy = 1'b1;
        #1;
        checks++;
        if (ch_rdy !== 4'b0010) begin
            errors++; $display("FAIL stall_resume: rdy=%b expected 0010", ch_rdy);
        end
        tick();
        ch_vld = '0;
    endtask

    task automatic test_release();
        do_reset();
        ch_vld = 4'b0100; atx_rdy = 1'b1;
        tick(); tick();
        cpl_vld = 1'b1; cpl_id = 5'd2;
        #1;
        checks++;
        if (ch_rdy !== 4'b0000) begin
            errors++; $display("FAIL release_same_cycle: rdy=%b expected 0000", ch_rdy);
        end
        tick();
        cpl_vld = 1'b0;
        checks++;
        if (ch_ostd[11:8] !== 4'd1) begin
            errors++; $display("FAIL release_cnt: cnt2=%0d expected 1", ch_ostd[11:8]);
        end
        #1;
        checks++;
        if (ch_rdy !== 4'b0100) begin
            errors++; $display("FAIL release_grant: rdy=%b expected 0100", ch_rdy);
        end
        tick();
        ch_vld = '0;
    endtask

    task automatic test_inc_dec();
        do_reset();
        ch_vld = 4'b0010; atx_rdy = 1'b1;
        tick();
        cpl_vld = 1'b1; cpl_id = 5'd1;
        #1;
        checks++;
        if (ch_rdy !== 4'b0010) begin
            errors++; $display("FAIL incdec_grant: rdy=%b expected 0010", ch_rdy);
        end
        tick();
        checks++;
        if (ch_ostd[7:4] !== 4'd1) begin
            errors++; $display("FAIL incdec_same: cnt1=%0d expected 1", ch_ostd[7:4]);
        end
        ch_vld = 4'b0001;
        tick();
        cpl_vld = 1'b0; ch_vld = '0;
        checks++;
        if (ch_ostd !== 16'h0001 || err !== 1'b0) begin
            errors++; $display("FAIL incdec_cross: ostd=%h err=%b expected 0001/0", ch_ostd, err);
        end
    endtask

    task automatic test_err();
        do_reset();
        cpl_vld = 1'b1; cpl_id = 5'b10011;
        tick();
        cpl_vld = 1'b0;
        checks++;
        if (err !== 1'b1 || ch_ostd !== 16'h0000) begin
            errors++; $display("FAIL err_underflow: err=%b ostd=%h expected 1/0000", err, ch_ostd);
        end
        tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: err=%b expected 1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear: err=%b expected 0", err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ch_vld = 4'b1111; atx_rdy = 1'b1;
        tick(); tick();
        atx_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (atx_vld !== 1'b0 || ch_ostd !== '0) begin
            errors++; $display("FAIL reset_mid: vld=%b ostd=%h expected 0/0000", atx_vld, ch_ostd);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        atx_rdy = 1'b1;
        #1;
        checks++;
        if (ch_rdy !== 4'b0001) begin
            errors++; $display("FAIL reset_mid_restart: rdy=%b expected 0001", ch_rdy);
        end
        tick();
        ch_vld = '0;
    endtask

    task automatic test_random();
        logic [CH-1:0] exp_rdy;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ch_axaddr  = {$urandom, $urandom, $urandom, $urandom};
            ch_axlen   = $urandom;
            ch_axburst = 8'($urandom);
            ch_vld     = 4'($urandom);
            atx_rdy    = ($urandom_range(0, 9) < 7);
            cpl_vld    = ($urandom_range(0, 2) == 0);
            cpl_id     = 5'($urandom);
            #1;
            exp_rdy = model_rdy();
            checks++;
            if (ch_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_rdy[%0d]: rdy=%b expected %b", n, ch_rdy, exp_rdy);
            end
            tick();
            checks++;
            if (atx_vld !== m_vld || ch_ostd !== model_ostd() || err !== m_err) begin
                errors++;
                $display("FAIL rand_state[%0d]: vld=%b ostd=%h err=%b expected %b/%h/%b",
                         n, atx_vld, ch_ostd, err, m_vld, model_ostd(), m_err);
            end
            if (m_vld) begin
                checks++;
                if (atx_axid !== 5'(m_id) || atx_axaddr !== m_addr || atx_axlen !== m_len || atx_axburst !== m_burst) begin
                    errors++;
                    $display("FAIL rand_payload[%0d]: id=%0d addr=%h len=%0d burst=%0d expected %0d/%h/%0d/%0d",
                             n, atx_axid, atx_axaddr, atx_axlen, atx_axburst, m_id, m_addr, m_len, m_burst);
                end
            end
        end
        cpl_vld = 1'b0; ch_vld = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_release();
        test_inc_dec();
        test_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
